// File: rtl/iter_mdu.sv
// Iterative multiply/divide unit with HI/LO registers: radix-2 shift-add multiply,
// restoring divide, multiply-accumulate, and direct HI/LO writes.
module iter_mdu #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  input  logic             flush,
  output logic             busy,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MADD  = 4'd5;
  localparam logic [3:0] OP_MADDU = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t state_q, state_d;

  logic [WIDTH-1:0] acc_hi, acc_lo, opb;
  logic [CNTW-1:0]  cnt;
  logic             is_div, neg_res, neg_rem, acc_add, acc_sub;

  // Operation decode, only meaningful while IDLE
  logic is_mul_op, is_div_op, signed_op, start, dz;
  logic [WIDTH-1:0] a_abs, b_abs;

  always_comb begin
    is_mul_op = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD) ||
                (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
    is_div_op = (op == OP_DIV) || (op == OP_DIVU);
    signed_op = (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
    dz        = (state_q == IDLE) && !flush && is_div_op && (b == '0);
    start     = (state_q == IDLE) && !flush && (is_mul_op || (is_div_op && (b != '0)));
    a_abs     = (signed_op && a[WIDTH-1]) ? -a : a;
    b_abs     = (signed_op && b[WIDTH-1]) ? -b : b;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CALC;
      CALC: begin
        if (flush)                               state_d = IDLE;
        else if (cnt == CNTW'(WIDTH - 1))        state_d = FIX;
      end
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

  // One iteration step for each algorithm
  logic [WIDTH:0] mul_sum, div_trial;
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
    div_trial = {acc_hi, acc_lo[WIDTH-1]} - {1'b0, opb};
  end

  // Sign fix-up and accumulate, evaluated against the current HI/LO
  logic [2*WIDTH-1:0] prod_s, mac_res;
  logic [WIDTH-1:0]   quo_s, rem_s;
  always_comb begin
    prod_s = neg_res ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    if (acc_add)      mac_res = {hi, lo} + prod_s;
    else if (acc_sub) mac_res = {hi, lo} - prod_s;
    else              mac_res = prod_s;
    quo_s = neg_res ? -acc_lo : acc_lo;
    rem_s = neg_rem ? -acc_hi : acc_hi;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi       <= '0;
      lo       <= '0;
      div_zero <= 1'b0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      opb      <= '0;
      cnt      <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      acc_add  <= 1'b0;
      acc_sub  <= 1'b0;
    end else begin
      div_zero <= dz;
      case (state_q)
        IDLE: begin
          if (!flush && op == OP_MTHI) hi <= a;
          if (!flush && op == OP_MTLO) lo <= a;
          if (start) begin
            acc_hi  <= '0;
            acc_lo  <= a_abs;
            opb     <= b_abs;
            cnt     <= '0;
            is_div  <= is_div_op;
            neg_res <= signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_rem <= signed_op && is_div_op && a[WIDTH-1];
            acc_add <= (op == OP_MADD) || (op == OP_MADDU);
            acc_sub <= (op == OP_MSUB) || (op == OP_MSUBU);
          end
        end
        CALC: begin
          if (!flush) begin
            cnt <= cnt + CNTW'(1);
            if (!is_div) begin
              acc_hi <= mul_sum[WIDTH:1];
              acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
            end else if (!div_trial[WIDTH]) begin
              acc_hi <= div_trial[WIDTH-1:0];
              acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
              acc_hi <= {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};
              acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
            end
          end
        end
        FIX: begin
          if (!flush) begin
            if (is_div) begin
              hi <= rem_s;
              lo <= quo_s;
            end else begin
              hi <= mac_res[2*WIDTH-1:WIDTH];
              lo <= mac_res[WIDTH-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iter_mdu.sv
// Directed bench for iter_mdu at WIDTH=32 with hand-computed HI/LO results.
module tb_iter_mdu;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] a = '0, b = '0;
  logic [3:0]  op = '0;
  logic        flush = 1'b0;
  logic        busy, div_zero;
  logic [31:0] hi, lo;

  int errors = 0;
  int checks = 0;

  iter_mdu #(.WIDTH(32), .CNTW(6)) dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .op(op), .flush(flush),
    .busy(busy), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present op/a/b for one edge; returns #1 after that edge
  task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    op = o; a = x; b = y;
    @(posedge clk); #1;
    op = '0; a = '0; b = '0;
  endtask

  // Full multi-cycle op: busy length, HI/LO stable while busy, final result
  task automatic run(input string tag, input logic [3:0] o, input logic [31:0] x,
                     input logic [31:0] y, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    logic [31:0] h0, l0;
    int n;
    logic stable;
    h0 = hi; l0 = lo; stable = 1'b1; n = 1;
    issue(o, x, y);
    check({tag, " busy_start"}, {63'd0, busy}, 64'd1);
    while (busy && n < 100) begin
      @(posedge clk); #1;
      if (busy) begin
        n++;
        if (hi !== h0 || lo !== l0) stable = 1'b0;
      end
    end
    check({tag, " busy_cycles"}, 64'(n), 64'd33);
    check({tag, " hilo_stable"}, {63'd0, stable}, 64'd1);
    check({tag, " hi"}, {32'd0, hi}, {32'd0, exp_hi});
    check({tag, " lo"}, {32'd0, lo}, {32'd0, exp_lo});
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", {63'd0, busy}, 64'd0);
    check("reset div_zero", {63'd0, div_zero}, 64'd0);
    check("reset hi", {32'd0, hi}, 64'd0);
    check("reset lo", {32'd0, lo}, 64'd0);
    @(negedge clk); reset = 1'b0;

    run("mult -1*2",   4'd1, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE);
    run("multu",       4'd2, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE);
    run("mult -3*4",   4'd1, 32'hFFFFFFFD, 32'd4, 32'hFFFFFFFF, 32'hFFFFFFF4);
    run("div -7/2",    4'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run("divu 7/2",    4'd4, 32'd7, 32'd2, 32'd1, 32'd3);
    run("div 7/-2",    4'd3, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD);
    run("div ovf",     4'd3, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000);

    // Divide by zero leaves HI/LO alone and pulses the flag once
    issue(4'd7, 32'd5, 32'd0);
    check("mthi busy", {63'd0, busy}, 64'd0);
    check("mthi hi", {32'd0, hi}, 64'd5);
    issue(4'd8, 32'd5, 32'd0);
    check("mtlo lo", {32'd0, lo}, 64'd5);
    issue(4'd4, 32'd7, 32'd0);
    check("dz pulse", {63'd0, div_zero}, 64'd1);
    check("dz busy", {63'd0, busy}, 64'd0);
    @(posedge clk); #1;
    check("dz pulse end", {63'd0, div_zero}, 64'd0);
    check("dz busy later", {63'd0, busy}, 64'd0);
    check("dz hi", {32'd0, hi}, 64'd5);
    check("dz lo", {32'd0, lo}, 64'd5);

    // Accumulate forms
    issue(4'd7, 32'd1, 32'd0);
    issue(4'd8, 32'hFFFFFFFF, 32'd0);
    run("madd 1*1",    4'd5, 32'd1, 32'd1, 32'd2, 32'd0);
    run("msub 1*1",    4'd9, 32'd1, 32'd1, 32'd1, 32'hFFFFFFFF);
    run("madd -1*1",   4'd5, 32'hFFFFFFFF, 32'd1, 32'd1, 32'hFFFFFFFE);
    run("msubu",       4'd10, 32'hFFFFFFFF, 32'd2, 32'd0, 32'd0);

    // Flush in CALC, with an op presented while busy
    issue(4'd7, 32'h11, 32'd0);
    issue(4'd8, 32'h22, 32'd0);
    issue(4'd1, 32'd3, 32'd4);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      op = (i == 5) ? 4'd8 : 4'd0;
      a  = (i == 5) ? 32'hDEAD : 32'd0;
      flush = (i == 10);
      @(posedge clk); #1;
      if (i == 5) check("ignored while busy", {32'd0, lo}, 64'h22);
    end
    @(negedge clk); flush = 1'b0; op = '0; a = '0;
    check("flush busy", {63'd0, busy}, 64'd0);
    check("flush hi", {32'd0, hi}, 64'h11);
    check("flush lo", {32'd0, lo}, 64'h22);
    repeat (40) @(posedge clk);
    #1;
    check("flush no late write", {hi, lo}, {32'h11, 32'h22});

    // Flush in IDLE cancels a register move
    @(negedge clk); op = 4'd7; a = 32'h99; flush = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); op = '0; a = '0; flush = 1'b0;
    check("idle flush mthi", {32'd0, hi}, 64'h11);

    // Reset mid-divide
    issue(4'd4, 32'd7, 32'd2);
    repeat (5) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    check("midreset busy", {63'd0, busy}, 64'd0);
    check("midreset hilo", {hi, lo}, 64'd0);
    @(negedge clk); reset = 1'b0;
    run("mult 3*4",    4'd1, 32'd3, 32'd4, 32'd0, 32'hC);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time limit so a stuck design still reaches a report
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
